// File: rtl/spi_i2c_pkg.sv
// Shared definitions for the SPI_to_I2C bridge sequencer: bridge command codes,
// program lengths, sequencer FSM states and the step -> frame program ROM.
package spi_i2c_pkg;

    localparam logic [7:0] CMD_START_ADDR = 8'h80;
    localparam logic [7:0] CMD_WRITE      = 8'h40;
    localparam logic [7:0] CMD_READ       = 8'h20;
    localparam logic [7:0] CMD_STOP       = 8'h10;
    localparam logic [7:0] CMD_FETCH      = 8'h00;

    localparam logic [2:0] WR_STEPS   = 3'd4;
    localparam logic [2:0] RD_STEPS   = 3'd6;
    localparam logic [2:0] FETCH_STEP = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CS_SETUP,
        S_SHIFT,
        S_CS_HOLD,
        S_GAP,
        S_DONE
    } seq_state_t;

    // Every program ends in STOP, so out-of-range steps fall back to it.
    function automatic logic [15:0] prog_frame(
        input logic       rnw,
        input logic [2:0] step,
        input logic [6:0] addr,
        input logic [7:0] regi,
        input logic [7:0] wdata
    );
        logic [15:0] f;
        f = {CMD_STOP, 8'hFF};
        if (!rnw) begin
            case (step)
                3'd0:    f = {CMD_START_ADDR, addr, 1'b0};
                3'd1:    f = {CMD_WRITE, regi};
                3'd2:    f = {CMD_WRITE, wdata};
                default: f = {CMD_STOP, 8'hFF};
            endcase
        end else begin
            case (step)
                3'd0:    f = {CMD_START_ADDR, addr, 1'b0};
                3'd1:    f = {CMD_WRITE, regi};
                3'd2:    f = {CMD_START_ADDR, addr, 1'b1};
                3'd3:    f = {CMD_READ, 8'hFF};
                3'd4:    f = {CMD_FETCH, 8'hFF};
                default: f = {CMD_STOP, 8'hFF};
            endcase
        end
        return f;
    endfunction

endpackage

// File: rtl/spi_frame_shifter.sv
// 16-bit SPI frame engine: one start pulse shifts a frame out MSB first in 32*CLK_DIV cycles;
// done is a combinational pulse in the last cycle, no backpressure once started.
module spi_frame_shifter #(
    parameter int CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] frame,
    input  logic        capture_en,
    input  logic        miso,
    output logic        done,
    output logic [7:0]  rx,
    output logic        sclk,
    output logic        mosi
);

    localparam int DW = $clog2(CLK_DIV);

    logic          busy;
    logic [DW-1:0] div;
    logic [4:0]    rises;
    logic [14:0]   sh;
    logic          half_end;

    assign half_end = busy && (div == DW'(CLK_DIV - 1));
    // Rise 1 lands on the start edge, so the trailing low half of period 16
    // closes the frame and the total stays at 32 half periods.
    assign done     = half_end && !sclk && (rises == 5'd16);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy  <= 1'b0;
            div   <= '0;
            rises <= '0;
            sh    <= '0;
            sclk  <= 1'b0;
            mosi  <= 1'b0;
            rx    <= '0;
        end else if (start) begin
            busy  <= 1'b1;
            div   <= '0;
            rises <= 5'd1;
            sclk  <= 1'b1;
            mosi  <= frame[15];
            sh    <= frame[14:0];
        end else if (busy) begin
            if (half_end) begin
                div <= '0;
                if (sclk) begin
                    sclk <= 1'b0;
                    if (capture_en && rises >= 5'd9)
                        rx <= {rx[6:0], miso};
                end else if (rises == 5'd16) begin
                    busy <= 1'b0;
                end else begin
                    sclk  <= 1'b1;
                    mosi  <= sh[14];
                    sh    <= {sh[13:0], 1'b0};
                    rises <= rises + 5'd1;
                end
            end else begin
                div <= div + 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_i2c_sequencer.sv
// Expands one register read/write request into SPI_to_I2C bridge frames; req_ready only in IDLE,
// rsp_valid pulses once after the final STOP frame and its gap (4 frames write, 6 frames read).
module spi_i2c_sequencer
    import spi_i2c_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int CS_SETUP   = 2,
    parameter int GAP_CYCLES = 2000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rnw,
    input  logic [6:0] req_addr,
    input  logic [7:0] req_reg,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       SPI_sclk,
    output logic       SPI_cs,
    output logic       SPI_mosi,
    input  logic       SPI_miso
);

    localparam int TMAX = (GAP_CYCLES > CS_SETUP) ? GAP_CYCLES : CS_SETUP;
    localparam int TW   = $clog2(TMAX + 1);

    seq_state_t    state, nxt;
    logic          rnw_q;
    logic [6:0]    addr_q;
    logic [7:0]    reg_q;
    logic [7:0]    wdata_q;
    logic [7:0]    rdata_q;
    logic [2:0]    step;
    logic [TW-1:0] tmr;

    logic          setup_end;
    logic          gap_end;
    logic          last_step;
    logic          start;
    logic          capture_en;
    logic          sh_done;
    logic [15:0]   frame;
    logic [7:0]    sh_rx;

    assign setup_end  = (tmr == TW'(CS_SETUP - 1));
    assign gap_end    = (tmr == TW'(GAP_CYCLES - 1));
    assign last_step  = (step == (rnw_q ? RD_STEPS - 3'd1 : WR_STEPS - 3'd1));
    assign capture_en = rnw_q && (step == FETCH_STEP);
    assign frame      = prog_frame(rnw_q, step, addr_q, reg_q, wdata_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= nxt;
    end

    always_comb begin
        nxt   = state;
        start = 1'b0;
        case (state)
            S_IDLE:     if (req_valid) nxt = S_LOAD;
            S_LOAD:     nxt = S_CS_SETUP;
            S_CS_SETUP: begin
                if (setup_end) begin
                    start = 1'b1;
                    nxt   = S_SHIFT;
                end
            end
            S_SHIFT:    if (sh_done) nxt = S_CS_HOLD;
            S_CS_HOLD:  if (setup_end) nxt = S_GAP;
            S_GAP:      if (gap_end) nxt = last_step ? S_DONE : S_LOAD;
            S_DONE:     nxt = S_IDLE;
            default:    nxt = S_IDLE;
        endcase
    end

    // One shared phase timer, cleared on every state change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            tmr <= '0;
        else if (nxt != state || state == S_IDLE)
            tmr <= '0;
        else
            tmr <= tmr + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rnw_q   <= 1'b0;
            addr_q  <= '0;
            reg_q   <= '0;
            wdata_q <= '0;
            step    <= '0;
        end else if (state == S_IDLE && req_valid) begin
            rnw_q   <= req_rnw;
            addr_q  <= req_addr;
            reg_q   <= req_reg;
            wdata_q <= req_wdata;
            step    <= '0;
        end else if (state == S_GAP && gap_end && !last_step) begin
            step <= step + 3'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rdata_q <= '0;
        else if (state == S_SHIFT && sh_done && capture_en)
            rdata_q <= sh_rx;
    end

    spi_frame_shifter #(
        .CLK_DIV (CLK_DIV)
    ) u_shifter (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .frame      (frame),
        .capture_en (capture_en),
        .miso       (SPI_miso),
        .done       (sh_done),
        .rx         (sh_rx),
        .sclk       (SPI_sclk),
        .mosi       (SPI_mosi)
    );

    assign SPI_cs    = !(state inside {S_CS_SETUP, S_SHIFT, S_CS_HOLD});
    assign req_ready = (state == S_IDLE);
    assign rsp_valid = (state == S_DONE);
    assign rsp_rdata = rdata_q;

endmodule
